l2_port_arbiter: RTL

- Shares the single L2 request port between NUM_REQ cache controllers (index 0 = icache controller, index 1 = dcache controller).
- Grants whole cache lines: once a requester is granted, it keeps the port until BEATS_PER_LINE beats are fulfilled or it drops its request. The port is never switched mid-line.
- Selection is round-robin. Sits between the L1 controllers and the L2 interface.

---
 rtl/xentry_pkg.sv | 31 +++
 rtl/l2_rr_picker.sv | 43 ++++
 rtl/l2_port_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/xentry_pkg.sv
// xentry_pkg
//   Shared types and constants for the L1 <-> L2 request path.
//   - memory_operation_e : operation carried on a request port
//   - arb_state_e        : L2 port arbiter ownership state
//   - WORDS_PER_LINE     : data beats per cache line
//   - rr_wrap()          : round-robin index helper (base + offset, mod n)
package xentry_pkg;

  typedef enum logic [1:0] {
    LOAD       = 2'd0,
    STORE      = 2'd1,
    MO_UNKNOWN = 2'd2
  } memory_operation_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_UNKNOWN = 2'd2
  } arb_state_e;

  localparam int WORDS_PER_LINE = 4;

  // (base + off) mod n, assuming base < n and off < n.
  function automatic int rr_wrap(input int base, input int off, input int n);
    int sum;
    sum = base + off;
    if (sum >= n) sum = sum - n;
    return sum;
  endfunction

endpackage

// File: rtl/l2_rr_picker.sv
// l2_rr_picker
//   Purely combinational round-robin selector. Scans req_valid starting at
//   rr_ptr and moving upward with wrap; the first set bit wins.
//   Ports:
//     req_valid [NUM_REQ] in  : per-requester request
//     rr_ptr    [GW]      in  : highest-priority index this round
//     any_req             out : at least one request pending
//     winner    [GW]      out : selected index (rr_ptr when no request)
module l2_rr_picker
  import xentry_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int GW      = 1
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [GW-1:0]      rr_ptr,
  output logic               any_req,
  output logic [GW-1:0]      winner
);

  // Candidate gi is the requester gi positions above rr_ptr (with wrap).
  logic [GW-1:0]      cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign cand_idx[gi] = GW'(rr_wrap(int'(rr_ptr), gi, NUM_REQ));
      assign cand_hit[gi] = req_valid[cand_idx[gi]];
    end
  endgenerate

  assign any_req = |req_valid;

  // Scan from the far end down so the nearest candidate is assigned last.
  always_comb begin
    winner = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) winner = cand_idx[k];
    end
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter
//   Shares one L2 request port between NUM_REQ L1 controllers
//   (0 = icache, 1 = dcache). Ownership is granted per whole line: the owner
//   keeps the port for BEATS_PER_LINE fulfilled beats or until it drops its
//   request. One idle cycle always separates two owners. Round-robin order.
//   Ports:
//     clk, reset_n                  : clock, async active-low reset
//     req_valid/type/address/wdata  : per-requester request (in)
//     req_fulfilled                 : per-requester beat-done pulse (out)
//     req_rdata                     : L2 load data, broadcast (out)
//     l2_req_valid/type/address/wdata : request toward L2 (out)
//     l2_req_fulfilled, l2_rdata    : L2 beat completion and data (in)
//     grant_id, busy                : current owner / port owned (out)
module l2_port_arbiter
  import xentry_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int BEATS_PER_LINE = WORDS_PER_LINE,
  localparam int GW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  memory_operation_e    req_type    [NUM_REQ],
  input  logic [ADDR_W-1:0]    req_address [NUM_REQ],
  input  logic [DATA_W-1:0]    req_wdata   [NUM_REQ],
  output logic [NUM_REQ-1:0]   req_fulfilled,
  output logic [DATA_W-1:0]    req_rdata,
  output logic                 l2_req_valid,
  output memory_operation_e    l2_req_type,
  output logic [ADDR_W-1:0]    l2_req_address,
  output logic [DATA_W-1:0]    l2_req_wdata,
  input  logic                 l2_req_fulfilled,
  input  logic [DATA_W-1:0]    l2_rdata,
  output logic [GW-1:0]        grant_id,
  output logic                 busy
);

  localparam int            BW        = $clog2(BEATS_PER_LINE) + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS_PER_LINE - 1);
  localparam logic [GW-1:0] LAST_REQ  = GW'(NUM_REQ - 1);

  arb_state_e    state_q,    state_d;
  logic [GW-1:0] rr_ptr_q,   rr_ptr_d;
  logic [GW-1:0] grant_id_q, grant_id_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;

  logic          any_req;
  logic [GW-1:0] winner;
  logic          owner_valid;
  logic          qual_ful;
  logic [GW-1:0] next_ptr;

  l2_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .any_req   (any_req),
    .winner    (winner)
  );

  assign owner_valid = req_valid[grant_id_q];
  // A beat only counts while the owner is actually presenting a request.
  assign qual_ful    = l2_req_fulfilled & owner_valid;
  assign next_ptr    = (grant_id_q == LAST_REQ) ? '0 : grant_id_q + GW'(1);
  assign grant_id    = grant_id_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_id_d     = grant_id_q;
    beat_cnt_d     = beat_cnt_q;
    busy           = 1'b0;
    l2_req_valid   = 1'b0;
    l2_req_type    = LOAD;
    l2_req_address = '0;
    l2_req_wdata   = '0;
    req_fulfilled  = '0;
    req_rdata      = l2_rdata;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_id_d = winner;
          beat_cnt_d = '0;
          state_d    = ST_GRANT;
        end
      end

      ST_GRANT: begin
        busy                      = 1'b1;
        l2_req_valid              = owner_valid;
        l2_req_type               = req_type[grant_id_q];
        l2_req_address            = req_address[grant_id_q];
        l2_req_wdata              = req_wdata[grant_id_q];
        req_fulfilled[grant_id_q] = qual_ful;

        // Abandon takes priority; a fulfilment then is already masked
        // because qual_ful requires owner_valid.
        if (!owner_valid || (qual_ful && beat_cnt_q == LAST_BEAT)) begin
          state_d    = ST_IDLE;
          rr_ptr_d   = next_ptr;
          beat_cnt_d = '0;
        end else if (qual_ful) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
        end
      end

      default: begin
        state_d        = ST_IDLE;
        busy           = 1'bx;
        l2_req_valid   = 1'bx;
        l2_req_type    = MO_UNKNOWN;
        l2_req_address = 'x;
        l2_req_wdata   = 'x;
        req_fulfilled  = 'x;
        req_rdata      = 'x;
      end
    endcase
  end

endmodule
